// File: rtl/piano_sequencer.sv
// piano_sequencer: mode select, lowest-key priority, ROM-driven song sequencer and square-wave tone.
// Latency: all outputs registered, 1 CLK after inputs; ROM data expected 1 CLK after rom_addr; no backpressure.
module piano_sequencer #(
  parameter int                          NUM_KEYS     = 8,
  parameter int                          NOTE_W       = 4,
  parameter int                          DIV_W        = 18,
  parameter logic [NUM_KEYS*DIV_W-1:0]   HALF_PERIODS = {8{18'd0}},
  parameter int                          ADDR_W       = 5,
  parameter int                          DUR_W        = 3,
  parameter int unsigned                 BEAT_CYCLES  = 25_000_000,
  parameter int unsigned                 GAP_CYCLES   = 2_500_000
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    mode_btn,
  input  logic [NUM_KEYS-1:0]     keys,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [NOTE_W+DUR_W-1:0] rom_data,
  output logic                    tone,
  output logic [NUM_KEYS-1:0]     led,
  output logic [NOTE_W-1:0]       note_idx,
  output logic [1:0]              mode,
  output logic                    song_done,
  output logic [7:0]              err_count
);

  typedef enum logic [1:0] {M_FREE, M_LESSON, M_AUTO} mode_e;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_PLAY, S_LISTEN, S_GAP, S_DONE} state_e;

  localparam logic [NOTE_W-1:0] SILENT = NOTE_W'(NUM_KEYS);
  localparam logic [31:0]       BEAT_L = BEAT_CYCLES;
  localparam logic [31:0]       GAP_L  = GAP_CYCLES;

  function automatic logic [NOTE_W-1:0] prio(input logic [NUM_KEYS-1:0] k);
    prio = SILENT;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (k[i]) prio = NOTE_W'(i);
  endfunction

  function automatic logic [NUM_KEYS-1:0] onehot(input logic [NOTE_W-1:0] n);
    onehot = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      onehot[i] = (n == NOTE_W'(i));
  endfunction

  // Out-of-range notes map to a zero half-period, i.e. silence.
  function automatic logic [DIV_W-1:0] half_of(input logic [NOTE_W-1:0] n);
    half_of = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (n == NOTE_W'(i)) half_of = HALF_PERIODS[i*DIV_W +: DIV_W];
  endfunction

  mode_e               mode_q, mode_n;
  state_e              state_q, state_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [7:0]          err_n;
  logic [NUM_KEYS-1:0] keys_q, press, led_n;
  logic [NOTE_W-1:0]   note_l, note_l_n, note_n, rom_note;
  logic [DUR_W-1:0]    dur_l, dur_l_n, rom_dur;
  logic [31:0]         seq_cnt, cnt_n, play_len;
  logic                fetch_wait, wait_n;
  logic [DIV_W-1:0]    tone_cnt, half_cur;

  assign press     = keys & ~keys_q;
  assign rom_note  = rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign rom_dur   = rom_data[DUR_W-1:0];
  assign play_len  = {{(32-DUR_W){1'b0}}, dur_l} * BEAT_L;
  assign half_cur  = half_of(note_idx);
  assign mode      = mode_q;
  assign song_done = (state_q == S_DONE);

  always_comb begin
    mode_n   = mode_q;
    state_n  = state_q;
    addr_n   = rom_addr;
    err_n    = err_count;
    note_l_n = note_l;
    dur_l_n  = dur_l;
    cnt_n    = seq_cnt;
    wait_n   = fetch_wait;
    if (mode_btn) begin
      case (mode_q)
        M_FREE:   mode_n = M_LESSON;
        M_LESSON: mode_n = M_AUTO;
        default:  mode_n = M_FREE;
      endcase
      state_n = S_IDLE;
      addr_n  = '0;
      err_n   = '0;
      cnt_n   = '0;
      wait_n  = 1'b0;
    end else if (mode_q != M_FREE) begin
      case (state_q)
        S_IDLE: begin
          addr_n  = '0;
          wait_n  = 1'b0;
          state_n = S_FETCH;
        end
        S_FETCH: begin
          if (!fetch_wait) begin
            wait_n = 1'b1;
          end else begin
            wait_n   = 1'b0;
            note_l_n = rom_note;
            dur_l_n  = rom_dur;
            cnt_n    = '0;
            if (rom_dur == '0)          state_n = S_DONE;
            else if (mode_q == M_AUTO)  state_n = S_PLAY;
            else if (rom_note >= SILENT) state_n = S_GAP;
            else                        state_n = S_LISTEN;
          end
        end
        S_PLAY: begin
          if (seq_cnt == play_len - 32'd1) begin
            state_n = S_GAP;
            cnt_n   = '0;
          end else begin
            cnt_n = seq_cnt + 32'd1;
          end
        end
        S_LISTEN: begin
          // Simultaneous presses: only the lowest-index one is judged.
          if (press != '0) begin
            if (prio(press) == note_l) begin
              state_n = S_GAP;
              cnt_n   = '0;
            end else if (err_count != 8'hFF) begin
              err_n = err_count + 8'd1;
            end
          end
        end
        S_GAP: begin
          if (seq_cnt == GAP_L - 32'd1) begin
            state_n = S_FETCH;
            addr_n  = rom_addr + 1'b1;
            cnt_n   = '0;
            wait_n  = 1'b0;
          end else begin
            cnt_n = seq_cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end

    // Outputs follow the state being entered so they line up with it.
    case (mode_n)
      M_AUTO: begin
        note_n = (state_n == S_PLAY && note_l_n < SILENT) ? note_l_n : SILENT;
        led_n  = onehot(note_n);
      end
      M_LESSON: begin
        note_n = prio(keys);
        led_n  = (state_n == S_LISTEN) ? onehot(note_l_n) : '0;
      end
      default: begin
        note_n = prio(keys);
        led_n  = keys;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mode_q     <= M_FREE;
      state_q    <= S_IDLE;
      rom_addr   <= '0;
      err_count  <= '0;
      keys_q     <= '0;
      note_l     <= '0;
      dur_l      <= '0;
      seq_cnt    <= '0;
      fetch_wait <= 1'b0;
      note_idx   <= SILENT;
      led        <= '0;
    end else begin
      mode_q     <= mode_n;
      state_q    <= state_n;
      rom_addr   <= addr_n;
      err_count  <= err_n;
      keys_q     <= keys;
      note_l     <= note_l_n;
      dur_l      <= dur_l_n;
      seq_cnt    <= cnt_n;
      fetch_wait <= wait_n;
      note_idx   <= note_n;
      led        <= led_n;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      tone     <= 1'b0;
      tone_cnt <= '0;
    end else if (mode_btn || note_n != note_idx) begin
      tone     <= 1'b0;
      tone_cnt <= '0;
    end else if (half_cur != '0) begin
      if (tone_cnt == half_cur - DIV_W'(1)) begin
        tone     <= ~tone;
        tone_cnt <= '0;
      end else begin
        tone_cnt <= tone_cnt + DIV_W'(1);
      end
    end else begin
      tone     <= 1'b0;
      tone_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_piano_sequencer.sv
// Bench for piano_sequencer: free-play vector table, autoplay run-length scoreboard, lesson, wrap, saturation.
module tb_piano_sequencer;
  logic       CLK;
  logic       RESET;
  logic       mode_btn;
  logic [7:0] keys;
  logic [4:0] rom_addr;
  logic [6:0] rom_data = '0;
  logic       tone;
  logic [7:0] led;
  logic [3:0] note_idx;
  logic [1:0] mode;
  logic       song_done;
  logic [7:0] err_count;

  logic [6:0] rom_mem [32];

  piano_sequencer #(
    .NUM_KEYS(8), .NOTE_W(4), .DIV_W(8),
    .HALF_PERIODS({8'd0, 8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3}),
    .ADDR_W(5), .DUR_W(3), .BEAT_CYCLES(10), .GAP_CYCLES(2)
  ) dut (
    .CLK(CLK), .RESET(RESET), .mode_btn(mode_btn), .keys(keys),
    .rom_addr(rom_addr), .rom_data(rom_data), .tone(tone), .led(led),
    .note_idx(note_idx), .mode(mode), .song_done(song_done), .err_count(err_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) rom_data <= rom_mem[rom_addr];

  int vecs = 0;
  int miss = 0;

  typedef struct { logic [7:0] k; logic [3:0] n; logic [7:0] l; } vec_t;
  typedef struct { logic [3:0] n; logic [7:0] l; } exp_t;
  typedef struct { logic [3:0] n; int len; } run_t;

  vec_t tbl [7];
  exp_t sbq [$];
  run_t runq [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic pulse_mode();
    mode_btn = 1'b1;
    tick(1);
    mode_btn = 1'b0;
  endtask

  task automatic wait_led(input logic [7:0] v, input int lim);
    for (int n = 0; n < lim && led !== v; n++) tick(1);
  endtask

  task automatic wait_addr(input logic [4:0] v, input int lim);
    for (int n = 0; n < lim && rom_addr !== v; n++) tick(1);
  endtask

  task automatic wait_note(input logic [3:0] v, input int lim);
    for (int n = 0; n < lim && note_idx !== v; n++) tick(1);
  endtask

  task automatic wait_done(input int lim);
    for (int n = 0; n < lim && song_done !== 1'b1; n++) tick(1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    exp_t       e;
    run_t       r;
    logic [3:0] prev;
    logic [7:0] oh;
    int         len, started, led_bad, hi_cnt;

    tbl[0] = '{8'h24, 4'd2, 8'h24};
    tbl[1] = '{8'h00, 4'd8, 8'h00};
    tbl[2] = '{8'h80, 4'd7, 8'h80};
    tbl[3] = '{8'hF0, 4'd4, 8'hF0};
    tbl[4] = '{8'h01, 4'd0, 8'h01};
    tbl[5] = '{8'hFF, 4'd0, 8'hFF};
    tbl[6] = '{8'h40, 4'd6, 8'h40};
    for (int i = 0; i < 32; i++) rom_mem[i] = '0;

    // Reset with every key held.
    RESET = 1'b0; mode_btn = 1'b0; keys = 8'hFF;
    tick(3);
    chk("rst_tone", 32'(tone), 32'd0);
    chk("rst_note", 32'(note_idx), 32'd8);
    chk("rst_led", 32'(led), 32'h00);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_done", 32'(song_done), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    keys = 8'h00;
    RESET = 1'b1;
    tick(1);

    // Free play table through the scoreboard queue.
    for (int i = 0; i < 7; i++) begin
      keys = tbl[i].k;
      sbq.push_back('{tbl[i].n, tbl[i].l});
      tick(1);
      e = sbq.pop_front();
      chk("free_note", 32'(note_idx), 32'(e.n));
      chk("free_led", 32'(led), 32'(e.l));
    end

    // Tone on key 2 (half-period 5): high for 5, low for 5.
    keys = 8'h24;
    tick(1);
    chk("tone_start", 32'(tone), 32'd0);
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      chk("tone_k2", 32'(tone), 32'((k / 5) % 2));
    end

    // Key 7 has a zero half-period and must stay silent.
    keys = 8'h80;
    tick(1);
    chk("k7_note", 32'(note_idx), 32'd7);
    hi_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      if (tone) hi_cnt++;
    end
    chk("k7_silent", 32'(hi_cnt), 32'd0);

    // Autoplay: {2,1},{9,2},{4,1},{0,0}.
    keys = 8'h00;
    rom_mem[0] = {4'd2, 3'd1};
    rom_mem[1] = {4'd9, 3'd2};
    rom_mem[2] = {4'd4, 3'd1};
    pulse_mode();
    pulse_mode();
    chk("auto_mode", 32'(mode), 32'd2);
    runq.push_back('{4'd2, 10});
    runq.push_back('{4'd8, 28});
    runq.push_back('{4'd4, 10});
    prev = note_idx; len = 0; started = 0; led_bad = 0;
    for (int c = 0; c < 300 && song_done !== 1'b1; c++) begin
      tick(1);
      oh = '0;
      if (note_idx < 4'd8) oh[note_idx[2:0]] = 1'b1;
      if (led !== oh) led_bad++;
      if (note_idx != prev) begin
        if (started != 0 && runq.size() > 0) begin
          r = runq.pop_front();
          chk("auto_run_note", 32'(prev), 32'(r.n));
          chk("auto_run_len", 32'(len), 32'(r.len));
        end
        if (note_idx != 4'd8) started = 1;
        prev = note_idx;
        len = 1;
      end else begin
        len++;
      end
    end
    chk("auto_runs_left", 32'(runq.size()), 32'd0);
    chk("auto_done", 32'(song_done), 32'd1);
    chk("auto_done_note", 32'(note_idx), 32'd8);
    chk("auto_led", 32'(led_bad), 32'd0);
    chk("auto_done_addr", 32'(rom_addr), 32'd3);

    // Mode change mid-song in autoplay.
    pulse_mode(); pulse_mode(); pulse_mode();
    wait_addr(5'd2, 100);
    chk("mid_addr2", 32'(rom_addr), 32'd2);
    keys = 8'h08;
    pulse_mode();
    chk("mid_mode", 32'(mode), 32'd0);
    chk("mid_addr", 32'(rom_addr), 32'd0);
    chk("mid_err", 32'(err_count), 32'd0);
    tick(1);
    chk("mid_note", 32'(note_idx), 32'd3);
    chk("mid_led", 32'(led), 32'h08);

    // Lesson: {3,1},{5,1},{0,0}.
    keys = 8'h00;
    rom_mem[0] = {4'd3, 3'd1};
    rom_mem[1] = {4'd5, 3'd1};
    rom_mem[2] = '0;
    tick(1);
    pulse_mode();
    wait_led(8'h08, 50);
    chk("les_led3", 32'(led), 32'h08);
    keys = 8'h02; tick(1); keys = 8'h00; tick(1);
    chk("les_err1", 32'(err_count), 32'd1);
    chk("les_stay", 32'(led), 32'h08);
    keys = 8'h28; tick(1);
    chk("les_hear", 32'(note_idx), 32'd3);
    keys = 8'h00;
    wait_led(8'h20, 50);
    chk("les_led5", 32'(led), 32'h20);
    chk("les_err_multi", 32'(err_count), 32'd1);
    chk("les_not_done", 32'(song_done), 32'd0);
    keys = 8'h20; tick(1); keys = 8'h00;
    wait_done(50);
    chk("les_done", 32'(song_done), 32'd1);
    chk("les_done_led", 32'(led), 32'h00);

    // Wrap: no dur=0 entry anywhere.
    for (int i = 0; i < 32; i++) rom_mem[i] = {4'd1, 3'd1};
    pulse_mode();
    chk("wrap_mode", 32'(mode), 32'd2);
    wait_addr(5'd31, 700);
    chk("wrap_addr31", 32'(rom_addr), 32'd31);
    wait_addr(5'd0, 60);
    chk("wrap_addr0", 32'(rom_addr), 32'd0);
    chk("wrap_not_done", 32'(song_done), 32'd0);
    wait_note(4'd1, 60);
    chk("wrap_play", 32'(note_idx), 32'd1);
    tick(6);

    // Asynchronous reset mid-song.
    RESET = 1'b0;
    #1;
    chk("arst_note", 32'(note_idx), 32'd8);
    chk("arst_tone", 32'(tone), 32'd0);
    chk("arst_led", 32'(led), 32'h00);
    chk("arst_mode", 32'(mode), 32'd0);
    chk("arst_addr", 32'(rom_addr), 32'd0);
    tick(2);
    RESET = 1'b1;
    tick(1);

    // Error counter saturation in lesson mode.
    rom_mem[0] = {4'd3, 3'd1};
    pulse_mode();
    wait_led(8'h08, 50);
    chk("sat_listen", 32'(led), 32'h08);
    for (int i = 0; i < 300; i++) begin
      keys = 8'h01; tick(1);
      keys = 8'h00; tick(1);
    end
    chk("sat_err", 32'(err_count), 32'd255);
    chk("sat_stay", 32'(led), 32'h08);
    pulse_mode();
    chk("sat_clear", 32'(err_count), 32'd0);
    chk("sat_mode", 32'(mode), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
